hamming_encoder_ext_stream: RTL and testbench
=============================================

# hamming_encoder_ext_stream

Streaming Extended Hamming (8,4) SEC-DED encoder. Accepts bytes over a valid/ready interface, splits each into two nibbles (low nibble first), and emits one 8-bit extended Hamming codeword per nibble over a valid/ready output. It sits on the transmit side of the channel, and `hamming_decoder_ext` is its receive-side counterpart. A per-byte error-injection mask lets benches exercise the decoder's correctable and uncorrectable paths.

## Interface
- `COUNT_W`, default 16: width of the emitted-codeword counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` and `in_inj_mask` are valid.
- `in_ready`  out  1: the block accepts a byte this cycle.
- `in_data`  in  8: payload byte; [3:0] is encoded first, [7:4] second.
- `in_inj_mask`  in  16: XOR mask applied after encoding; [7:0] to the low-nibble codeword, [15:8] to the high-nibble codeword. Tie to 0 in normal use.
- `out_valid`  out  1: `out_data` holds a codeword.
- `out_ready`  in  1: the downstream consumer accepts the codeword.
- `out_data`  out  8: codeword.
- `cw_count`  out  COUNT_W: number of codewords accepted downstream; wraps modulo 2^COUNT_W.

## Operation
- Nibble bits d[3:0] map into codeword cw[7:0] as follows:
  - cw[2]=d0, cw[4]=d1, cw[5]=d2, cw[6]=d3.
  - cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[3]=d1^d2^d3.
  - cw[7]=^cw[6:0], so the whole word has even parity.
- Mask application: `out_data` = encoded codeword XOR the corresponding 8-bit slice of the registered mask.
- Registered state: FSM state, held byte, held mask, `out_data`, `out_valid`, `cw_count`.
- FSM states: IDLE (no output), LO (low codeword presented), HI (high codeword presented).
- FSM transitions:
  - IDLE: if `in_valid` is high, capture the byte and mask, load the low codeword, go to LO. Otherwise stay in IDLE.
  - LO: if `out_ready` is high, load the high codeword from the held byte and go to HI. Otherwise hold.
  - HI: if `out_ready` and `in_valid` are both high, capture the new byte, load its low codeword, go to LO. If only `out_ready` is high, go to IDLE. Otherwise hold.
- `in_ready` is combinational: high in IDLE, or in HI while `out_ready` is high. It never depends on `in_valid`.
- `out_valid` is high exactly in LO and HI.
- `cw_count` increments on every cycle where `out_valid` and `out_ready` are both high.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0x00, `cw_count`=0, held byte/mask=0. `in_ready`=1 while `rst` is low and the FSM is in IDLE.
- Reset mid-byte discards the pending byte and any unsent high codeword. Nothing is emitted for it after reset deasserts.
- Latency: byte accepted at edge N gives its low codeword valid from edge N, and its high codeword from the first edge after the low codeword is accepted.
- Throughput: with `out_ready` held high and `in_valid` held high, one codeword every cycle (one byte per 2 cycles), with no bubble between bytes.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and the state are held stable.
- `in_data` changing while `in_ready`=0 has no effect.
- Simultaneous in-fire and out-fire in HI: the HI codeword is consumed and the new low codeword appears the next cycle. `cw_count` increments once.
- `cw_count` at all ones plus one fire wraps to 0.

## Test plan
- Reset defaults: assert `rst` asynchronously mid-cycle. Outputs go to their reset values immediately, with no clock edge required.
- Basic encode, `out_ready`=1: send bytes 0x00, 0xFF, 0xA1, 0x35 with mask 0.
  - Required `out_data` sequence: 0x00, 0x00, 0xFF, 0xFF, 0x87, 0xD2, 0x2D, 0x1E.
  - `cw_count`=8 at the end.
  - Each codeword fed to `hamming_decoder_ext` returns the original nibble with both error flags low.
- Backpressure: byte 0xA1, with `out_ready` low for 3 cycles in LO, then high.
  - `out_data` holds 0x87 for all 4 cycles with `in_ready`=0, then becomes 0xD2.
  - `cw_count` increments only on the fire cycles.
- Back-to-back streaming: 16 consecutive random bytes with `in_valid` and `out_ready` held high.
  - 32 codewords emitted on 32 consecutive cycles, in order.
  - Decoder round-trip reproduces the bytes.
- Error injection: byte 0xA1 with mask 0x0800.
  - Codewords emitted: 0x87 and 0xDA.
  - Decoder reports no error for the first codeword, and `correctable_error` with corrected nibble 0xA for the second.
  - Same byte with mask 0x0003: first codeword 0x84, decoder reports `uncorrectable_error`.
- Reset mid-operation and counter wrap:
  - Assert reset while in LO: no high codeword ever appears, and the next byte after reset starts cleanly.
  - With COUNT_W=4, 17 codewords leave `cw_count`=1.

Source files
------------

// File: rtl/hamming_encoder_ext_stream.sv
// Streaming extended Hamming (8,4) SEC-DED encoder: one byte in, two codewords out
// (low nibble first). An optional per-byte XOR mask corrupts codewords to exercise a decoder.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no codeword presented; a byte is taken as soon as it is valid
// LO    | low-nibble codeword of the held byte presented
// HI    | high-nibble codeword presented; a new byte may enter on its fire
module hamming_encoder_ext_stream #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic [15:0]        in_inj_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [COUNT_W-1:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [7:0]  held_data;
    logic [15:0] held_mask;
    logic        out_fire;

    // cw[7] is overall parity so single errors (odd) and double errors (even) are distinguishable.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return {^c, c};
    endfunction

    assign in_ready = (state == IDLE) || ((state == HI) && out_ready);
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            held_data <= 8'h00;
            held_mask <= 16'h0000;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            cw_count  <= '0;
        end else begin
            if (out_fire) begin
                cw_count <= cw_count + CNT_ONE;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        held_data <= in_data;
                        held_mask <= in_inj_mask;
                        out_data  <= encode(in_data[3:0]) ^ in_inj_mask[7:0];
                        out_valid <= 1'b1;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (out_ready) begin
                        out_data <= encode(held_data[7:4]) ^ held_mask[15:8];
                        state    <= HI;
                    end
                end
                HI: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            held_data <= in_data;
                            held_mask <= in_inj_mask;
                            out_data  <= encode(in_data[3:0]) ^ in_inj_mask[7:0];
                            state     <= LO;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_ext_stream.sv
// Bench for hamming_encoder_ext_stream: queue-based reference model plus a
// syndrome decoder, with one task per scenario.
module tb_hamming_encoder_ext_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_w4;
    logic [7:0]  in_data;
    logic [15:0] in_inj_mask;
    logic        out_valid;
    logic        out_valid_w4;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_data_w4;
    logic [15:0] cw_count;
    logic [3:0]  cw_count_w4;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    int unsigned exp_count;

    hamming_encoder_ext_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cw_count(cw_count)
    );

    hamming_encoder_ext_stream #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w4),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid_w4),
        .out_ready(out_ready), .out_data(out_data_w4), .cw_count(cw_count_w4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Positional Hamming(7,4): data at positions 3,5,6,7; parity at position p covers every position with bit p set.
    function automatic logic [7:0] ref_encode(input logic [3:0] nib);
        logic [7:0] w;
        logic       par;
        int         dpos[4];
        dpos = '{3, 5, 6, 7};
        w = 8'h00;
        for (int k = 0; k < 4; k++) w[dpos[k] - 1] = nib[k];
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos & p) != 0) && (pos != p)) par = par ^ w[pos - 1];
            w[p - 1] = par;
        end
        w[7] = ^w[6:0];
        return w;
    endfunction

    // Returns {uncorrectable, correctable, nibble}.
    function automatic logic [5:0] ref_decode(input logic [7:0] w);
        int         syn;
        logic [7:0] c;
        syn = 0;
        c = w;
        for (int pos = 1; pos <= 7; pos++) if (w[pos - 1]) syn = syn ^ pos;
        if (^w) begin
            if (syn != 0) c[syn - 1] = ~c[syn - 1];
            return {1'b0, 1'b1, c[6], c[5], c[4], c[2]};
        end
        if (syn != 0) return {1'b1, 1'b0, c[6], c[5], c[4], c[2]};
        return {1'b0, 1'b0, c[6], c[5], c[4], c[2]};
    endfunction

    // Byte may enter when nothing would remain pending after this cycle's output fire.
    function automatic logic exp_in_ready();
        return (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_count = 0;
    endtask

    // Records what the DUT hands off this cycle, advances the model, moves to the next falling edge.
    task automatic tick(output bit fired, output logic [7:0] fired_data);
        bit ofire;
        bit ifire;
        fired      = out_valid && out_ready;
        fired_data = out_data;
        ofire = (exp_q.size() != 0) && out_ready;
        ifire = in_valid && exp_in_ready();
        if (ofire) begin
            void'(exp_q.pop_front());
            exp_count++;
        end
        if (ifire) begin
            exp_q.push_back(ref_encode(in_data[3:0]) ^ in_inj_mask[7:0]);
            exp_q.push_back(ref_encode(in_data[7:4]) ^ in_inj_mask[15:8]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit         f;
        logic [7:0] fd;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00; in_inj_mask = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || cw_count !== 16'h0000 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_defaults: got valid=%b data=%h count=%0d in_ready=%b, need 0 00 0 1", out_valid, out_data, cw_count, in_ready);
        end
        in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        tick(f, fd);
        in_valid = 1'b0;
        tick(f, fd);
        out_ready = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || cw_count !== 16'(exp_count)) begin
            n_err++;
            $display("FAIL reset_preload: got valid=%b data=%h count=%0d, need 1 %h %0d", out_valid, out_data, cw_count, exp_q[0], exp_count);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || cw_count !== 16'h0000 || out_valid_w4 !== 1'b0 || cw_count_w4 !== 4'h0) begin
            n_err++;
            $display("FAIL reset_async: got valid=%b data=%h count=%0d w4valid=%b w4count=%0d, need all zero", out_valid, out_data, cw_count, out_valid_w4, cw_count_w4);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] bytes[4];
        logic [7:0] want[8];
        logic [7:0] got[$];
        logic [7:0] b;
        logic [3:0] nib;
        logic [5:0] dec;
        bit         f;
        logic [7:0] fd;
        int         bi;
        int         guard;
        bytes = '{8'h00, 8'hFF, 8'hA1, 8'h35};
        want  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h87, 8'hD2, 8'h2D, 8'h1E};
        bi = 0; guard = 0;
        out_ready = 1'b1; in_inj_mask = 16'h0000;
        while ((bi < 4 || exp_q.size() != 0) && guard < 40) begin
            in_valid = (bi < 4);
            in_data  = bytes[(bi < 4) ? bi : 0];
            #1;
            n_vec++;
            if (in_ready !== exp_in_ready() || out_valid !== (exp_q.size() != 0) || (exp_q.size() != 0 && out_data !== exp_q[0])) begin
                n_err++;
                $display("FAIL basic_cycle%0d: got in_ready=%b valid=%b data=%h, need %b %b %h", guard, in_ready, out_valid, out_data, exp_in_ready(), exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
            end
            if (in_valid && exp_in_ready()) bi++;
            tick(f, fd);
            if (f) got.push_back(fd);
            guard++;
        end
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (got.size() != 8 || cw_count !== 16'd8) begin
            n_err++;
            $display("FAIL basic_count: got %0d codewords, cw_count=%0d, need 8 and 8", got.size(), cw_count);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            b   = bytes[i / 2];
            nib = (i % 2 == 0) ? b[3:0] : b[7:4];
            dec = ref_decode(got[i]);
            n_vec++;
            if (got[i] !== want[i] || dec !== {2'b00, nib}) begin
                n_err++;
                $display("FAIL basic_cw%0d: got %h (decodes %b), need %h (decodes 00%b)", i, got[i], dec, want[i], nib);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic       iv[7];
        logic       ordy[7];
        logic       ev[7];
        logic [7:0] ed[7];
        logic       eir[7];
        int         dc[7];
        int         base;
        bit         f;
        logic [7:0] fd;
        iv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ordy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ev   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed   = '{8'h00, 8'h87, 8'h87, 8'h87, 8'h87, 8'hD2, 8'h00};
        eir  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        dc   = '{0, 0, 0, 0, 0, 1, 2};
        base = int'(cw_count);
        in_inj_mask = 16'h0000;
        for (int c = 0; c < 7; c++) begin
            in_valid  = iv[c];
            in_data   = (c == 0) ? 8'hA1 : 8'($urandom_range(255));
            out_ready = ordy[c];
            #1;
            n_vec++;
            if (out_valid !== ev[c] || (ev[c] && out_data !== ed[c]) || in_ready !== eir[c] || cw_count !== 16'(base + dc[c])) begin
                n_err++;
                $display("FAIL backpressure_c%0d: got valid=%b data=%h in_ready=%b count=%0d, need %b %h %b %0d", c, out_valid, out_data, in_ready, cw_count, ev[c], ed[c], eir[c], base + dc[c]);
            end
            tick(f, fd);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[16];
        logic [7:0] got[$];
        bit         f;
        logic [7:0] fd;
        int         bi;
        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(255));
        bi = 0;
        out_ready = 1'b1; in_inj_mask = 16'h0000;
        for (int c = 0; c < 33; c++) begin
            in_valid = (bi < 16);
            in_data  = bytes[(bi < 16) ? bi : 0];
            #1;
            n_vec++;
            if ((c > 0 && out_valid !== 1'b1) || (exp_q.size() != 0 && out_data !== exp_q[0]) || in_ready !== exp_in_ready()) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: got valid=%b data=%h in_ready=%b, need valid=%b data=%h in_ready=%b", c, out_valid, out_data, in_ready, c > 0, (exp_q.size() != 0) ? exp_q[0] : 8'h00, exp_in_ready());
            end
            if (in_valid && exp_in_ready()) bi++;
            tick(f, fd);
            if (f) got.push_back(fd);
        end
        in_valid = 1'b0;
        n_vec++;
        if (got.size() != 32) begin
            n_err++;
            $display("FAIL b2b_count: got %0d codewords, need 32", got.size());
        end
        for (int i = 0; i < 16 && 2 * i + 1 < got.size(); i++) begin
            logic [5:0] dlo;
            logic [5:0] dhi;
            dlo = ref_decode(got[2 * i]);
            dhi = ref_decode(got[2 * i + 1]);
            n_vec++;
            if ({dhi, dlo} !== {2'b00, bytes[i][7:4], 2'b00, bytes[i][3:0]}) begin
                n_err++;
                $display("FAIL b2b_byte%0d: got codewords %h %h, need decode of byte %h", i, got[2 * i], got[2 * i + 1], bytes[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_inject();
        logic [15:0] masks[2];
        logic [7:0]  got[$];
        logic [5:0]  d0;
        logic [5:0]  d1;
        bit          f;
        logic [7:0]  fd;
        int          guard;
        masks = '{16'h0800, 16'h0003};
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            got.delete();
            in_valid = 1'b1; in_data = 8'hA1; in_inj_mask = masks[m];
            #1;
            tick(f, fd);
            in_valid = 1'b0;
            guard = 0;
            while (exp_q.size() != 0 && guard < 10) begin
                #1;
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL inject%0d_cycle: got valid=%b data=%h, need 1 %h", m, out_valid, out_data, exp_q[0]);
                end
                tick(f, fd);
                if (f) got.push_back(fd);
                guard++;
            end
            if (got.size() != 2) begin
                n_vec++;
                n_err++;
                $display("FAIL inject%0d_count: got %0d codewords, need 2", m, got.size());
            end else begin
                d0 = ref_decode(got[0]);
                d1 = ref_decode(got[1]);
                n_vec++;
                if (m == 0 && (got[0] !== 8'h87 || got[1] !== 8'hDA || d0 !== 6'b00_0001 || d1 !== 6'b01_1010)) begin
                    n_err++;
                    $display("FAIL inject_single: got %h %h flags %b %b, need 87 DA with 000001 011010", got[0], got[1], d0, d1);
                end
                if (m == 1 && (got[0] !== 8'h84 || d0[5] !== 1'b1 || got[1] !== 8'hD2)) begin
                    n_err++;
                    $display("FAIL inject_double: got %h uncorrectable=%b then %h, need 84 1 D2", got[0], d0[5], got[1]);
                end
            end
        end
        in_inj_mask = 16'h0000;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[$];
        bit         f;
        logic [7:0] fd;
        int         guard;
        in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b0; in_inj_mask = 16'h0000;
        #1;
        tick(f, fd);
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL midreset_lo: got valid=%b data=%h, need 1 %h", out_valid, out_data, exp_q[0]);
        end
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (out_valid !== 1'b0 || cw_count !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_async: got valid=%b count=%0d, need 0 0", out_valid, cw_count);
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midreset_quiet%0d: got valid=%b data=%h in_ready=%b, need 0 and 1", c, out_valid, out_data, in_ready);
            end
            tick(f, fd);
        end
        in_valid = 1'b1; in_data = 8'h3B;
        #1;
        tick(f, fd);
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            tick(f, fd);
            if (f) got.push_back(fd);
            guard++;
        end
        #1;
        n_vec++;
        if (got.size() != 2 || got[0] !== ref_encode(4'hB) || got[1] !== ref_encode(4'h3) || cw_count !== 16'd2) begin
            n_err++;
            $display("FAIL midreset_restart: got %0d codewords first=%h count=%0d, need 2 first=%h count=2", got.size(), (got.size() != 0) ? got[0] : 8'h00, cw_count, ref_encode(4'hB));
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit         f;
        logic [7:0] fd;
        int         fires;
        int         guard;
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; in_inj_mask = 16'h0000;
        fires = 0; guard = 0;
        while (fires < 17 && guard < 60) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(255));
            #1;
            n_vec++;
            if (out_valid !== (exp_q.size() != 0) || (exp_q.size() != 0 && out_data !== exp_q[0]) || cw_count_w4 !== 4'(exp_count)) begin
                n_err++;
                $display("FAIL wrap_cycle%0d: got valid=%b data=%h w4count=%0d, need %b %h %0d", guard, out_valid, out_data, cw_count_w4, exp_q.size() != 0, (exp_q.size() != 0) ? exp_q[0] : 8'h00, exp_count % 16);
            end
            tick(f, fd);
            if (f) fires++;
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_vec++;
        if (fires != 17 || cw_count_w4 !== 4'd1 || cw_count !== 16'd17) begin
            n_err++;
            $display("FAIL wrap_count: got fires=%0d w4count=%0d count=%0d, need 17 1 17", fires, cw_count_w4, cw_count);
        end
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            tick(f, fd);
            guard++;
        end
        #1;
        n_vec++;
        if (cw_count_w4 !== 4'd2 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_drain: got w4count=%0d valid=%b, need 2 0", cw_count_w4, out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_inject();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion before 200000");
        $fatal(1);
    end

endmodule
